// File: rtl/found_bcd_conv_pkg.sv
// Shared types and constants for the match-address to BCD converter.
package found_bcd_conv_pkg;
  localparam int BCD_W      = 4;
  localparam int DIGITS     = 4;
  localparam int BCD_TOT    = BCD_W * DIGITS;
  localparam int MAX_IN_W   = 13;
  localparam int CNT_W      = 4;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  typedef logic [DIGITS-1:0][BCD_W-1:0] bcd_t;
endpackage

// File: rtl/found_bcd_conv_if.sv
// Search-result input and seven-segment digit output bundle.
interface found_bcd_conv_if #(parameter int IN_W = 8);
  logic            done;
  logic [IN_W-1:0] found;
  logic [3:0]      thousands;
  logic [3:0]      hundreds;
  logic [3:0]      tens;
  logic [3:0]      units;
  logic            busy;
  logic            bcd_valid;
  logic            overrun;

  modport master (output done, found,
                  input  thousands, hundreds, tens, units, busy, bcd_valid, overrun);
  modport slave  (input  done, found,
                  output thousands, hundreds, tens, units, busy, bcd_valid, overrun);
endinterface

// File: rtl/found_bcd_conv_add3.sv
// Double-dabble nibble adjust: values 5..9 get +3 before the shift.
module bcd_add3
  import found_bcd_conv_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);
  assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;
endmodule

// File: rtl/found_bcd_conv.sv
// Captures found on a done rising edge and converts it to 4 BCD digits, one bit per cycle.
// Optional build macro: BLANK_LEADING_ZERO_EN (leading zero digits shown as blank code).
module found_bcd_conv
  import found_bcd_conv_pkg::*;
#(
  parameter int IN_W = 8
)(
  input  logic              CLK100MHZ,
  input  logic              reset,
  found_bcd_conv_if.slave   bus
);
  if (IN_W < 4 || IN_W > MAX_IN_W) begin : g_bad_w
    $error("found_bcd_conv: IN_W=%0d outside 4..%0d", IN_W, MAX_IN_W);
  end

  state_t              state_q, state_d;
  logic                done_d;
  logic [IN_W-1:0]     bin;
  bcd_t                bcd, adj, load_digits;
  logic [CNT_W-1:0]    cnt;
  bcd_t                digits;
  logic                busy, bcd_valid, overrun;
  logic [BCD_TOT+IN_W-1:0] shifted;
  logic                trig;

  assign trig = bus.done & ~done_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.din(bcd[g]), .dout(adj[g]));
  end

  assign shifted = {adj, bin} << 1;

  // Blanking walks from the most significant digit and stops at the first non-zero one.
  always_comb begin
    load_digits = bcd;
`ifdef BLANK_LEADING_ZERO_EN
    if (bcd[3] == '0) begin
      load_digits[3] = BLANK_CODE;
      if (bcd[2] == '0) begin
        load_digits[2] = BLANK_CODE;
        if (bcd[1] == '0) load_digits[1] = BLANK_CODE;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig) state_d = CONV;
      CONV:    if (cnt == '0) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      done_d    <= 1'b0;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      digits    <= '0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_d    <= bus.done;
      bcd_valid <= 1'b0;
      overrun   <= trig && (state_q != IDLE);
      case (state_q)
        IDLE: if (trig) begin
          bin  <= bus.found;
          bcd  <= '0;
          cnt  <= CNT_W'(IN_W - 1);
          busy <= 1'b1;
        end
        CONV: begin
          {bcd, bin} <= shifted;
          cnt        <= cnt - 1'b1;
        end
        LOAD: begin
          digits    <= load_digits;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.thousands = digits[3];
  assign bus.hundreds  = digits[2];
  assign bus.tens      = digits[1];
  assign bus.units     = digits[0];
  assign bus.busy      = busy;
  assign bus.bcd_valid = bcd_valid;
  assign bus.overrun   = overrun;
endmodule

// File: tb/tb_found_bcd_conv.sv
// Directed bench for found_bcd_conv; expectations follow BLANK_LEADING_ZERO_EN when defined.
module tb_found_bcd_conv;
  localparam int IN_W = 8;
`ifdef BLANK_LEADING_ZERO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  found_bcd_conv_if #(.IN_W(IN_W)) bus ();

  found_bcd_conv #(.IN_W(IN_W)) dut (
    .CLK100MHZ (clk),
    .reset     (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digs();
    return {bus.thousands, bus.hundreds, bus.tens, bus.units};
  endfunction

  // Raise done with a new address, hold it ncyc cycles, then check latency, pulse count and digits.
  task automatic do_conv(input string tag, input int v, input logic [15:0] exp, input int ncyc);
    int first;
    int pulses;
    first  = -1;
    pulses = 0;
    @(negedge clk);
    bus.found = IN_W'(v);
    bus.done  = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == 1) chk({tag, ".busy_rise"}, 32'(bus.busy), 32'd1);
      if (bus.bcd_valid) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    bus.done = 1'b0;
    chk({tag, ".latency"}, 32'(first), 32'd10);
    chk({tag, ".pulses"}, 32'(pulses), 32'd1);
    chk({tag, ".digits"}, 32'(digs()), 32'(exp));
    chk({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int pulses;
    int ovr;
    rst_n     = 1'b0;
    bus.done  = 1'b0;
    bus.found = '0;
    #12;
    chk("rst.digits", 32'(digs()), 32'h0);
    chk("rst.flags", {29'd0, bus.busy, bus.bcd_valid, bus.overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_conv("c206", 206, BLANK ? 16'hF206 : 16'h0206, 20);
    do_conv("c255", 255, BLANK ? 16'hF255 : 16'h0255, 20);
    do_conv("c0_hold50", 0, BLANK ? 16'hFFF0 : 16'h0000, 50);
    do_conv("c9", 9, BLANK ? 16'hFFF9 : 16'h0009, 20);
    do_conv("c100", 100, BLANK ? 16'hF100 : 16'h0100, 20);
    do_conv("c0", 0, BLANK ? 16'hFFF0 : 16'h0000, 20);

    // Second rising edge of done three cycles into a conversion must be dropped.
    @(negedge clk);
    bus.found = 8'd206;
    bus.done  = 1'b1;
    @(negedge clk);
    bus.done  = 1'b0;
    pulses = 0;
    ovr    = 0;
    @(negedge clk);
    @(negedge clk);
    bus.found = 8'd7;
    bus.done  = 1'b1;
    @(negedge clk);
    chk("ovr.pulse", 32'(bus.overrun), 32'd1);
    @(negedge clk);
    chk("ovr.single", 32'(bus.overrun), 32'd0);
    bus.done = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.bcd_valid) pulses++;
      if (bus.overrun) ovr++;
    end
    chk("ovr.valid_count", 32'(pulses), 32'd1);
    chk("ovr.no_more_ovr", 32'(ovr), 32'd0);
    chk("ovr.digits", 32'(digs()), BLANK ? 32'hF206 : 32'h0206);

    // Reset mid-conversion aborts and clears the held digits.
    @(negedge clk);
    bus.found = 8'd99;
    bus.done  = 1'b1;
    for (int n = 0; n < 4; n++) @(negedge clk);
    chk("abort.busy_before", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.digits", 32'(digs()), 32'h0);
    chk("abort.flags", {29'd0, bus.busy, bus.bcd_valid, bus.overrun}, 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.done = ~bus.done;
      chk("abort.held", {12'd0, digs(), 1'b0, bus.busy, bus.bcd_valid, bus.overrun}, 32'd0);
    end
    @(negedge clk);
    bus.done = 1'b0;
    rst_n    = 1'b1;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.bcd_valid || bus.overrun || bus.busy) pulses++;
    end
    chk("abort.quiet_after", 32'(pulses), 32'd0);
    do_conv("c42", 42, BLANK ? 16'hFF42 : 16'h0042, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
